mgmt_port_config_regs: RTL and testbench

Byte-wide management register file sitting behind the QSPI/simulation management bridge, generalising the per-port configuration block to a parametrised port count with full read-back, atomic multi-byte commits, bus error reporting and bounded read stalls. It serves FPGA die information and per-port VLAN and tag-mode configuration in the management clock domain. It drives per-port update strobes for the per-port RegisterSynchronizer instances, which live outside this block.

---
 rtl/mgmt_port_config_regs_pkg.sv | 18 +
 rtl/mgmt_port_cfg_slice.sv | 64 ++++++
 rtl/mgmt_port_config_regs.sv | 148 ++++++++++++++
 tb/tb_mgmt_port_config_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_port_config_regs_pkg.sv
// mgmt_regs_pkg: shared types and register map of the management register file
package mgmt_regs_pkg;
  typedef logic [11:0] vlan_t;
  typedef enum logic [15:0] {
    REG_IDCODE     = 16'h0000,
    REG_DIE_SERIAL = 16'h0004,
    REG_PORT_COUNT = 16'h000c
  } regid_t;
  typedef enum logic [1:0] {
    IF_VLAN_NUM    = 2'd0,
    IF_VLAN_NUM_1  = 2'd1,
    IF_TAG_MODE    = 2'd2,
    IF_LINK_STATUS = 2'd3
  } ifoff_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  localparam logic [15:0] INTERFACE_STRIDE = 16'h0400;
  localparam logic [3:0] TAG_RESET = 4'b0010;
endpackage

// File: rtl/mgmt_port_cfg_slice.sv
// mgmt_port_cfg_slice: one port's VLAN shadow/commit, tag mode, update strobes and read-back
module mgmt_port_cfg_slice
  import mgmt_regs_pkg::*;
#(
  parameter vlan_t DEFAULT_VLAN = 12'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  ifoff_t     wr_off_i,
  input  logic [7:0] wr_data_i,
  input  ifoff_t     rd_off_i,
  input  logic       link_up_i,
  output vlan_t      vlan_o,
  output logic       vlan_upd_o,
  output logic [3:0] tag_o,
  output logic       tag_upd_o,
  output logic [7:0] rd_data_o
);
  logic [7:0] shadow_q, shadow_d;
  vlan_t      vlan_q, vlan_d;
  logic [3:0] tag_q, tag_d;
  logic       vlan_upd_q, vlan_upd_d, tag_upd_q, tag_upd_d, init_q;
  logic       commit, tag_wr;
  // Next state: low byte only loads the shadow, high byte commits both halves at once
  always_comb begin
    commit     = wr_en_i && wr_off_i == IF_VLAN_NUM_1;
    tag_wr     = wr_en_i && wr_off_i == IF_TAG_MODE;
    shadow_d   = wr_en_i && wr_off_i == IF_VLAN_NUM ? wr_data_i : shadow_q;
    vlan_d     = commit ? {wr_data_i[3:0], shadow_q} : vlan_q;
    tag_d      = tag_wr ? wr_data_i[3:0] : tag_q;
    vlan_upd_d = init_q || commit;
    tag_upd_d  = init_q || tag_wr;
  end
  // State registers; init_q forces one strobe after reset so downstream loads defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= DEFAULT_VLAN[7:0];
      vlan_q     <= DEFAULT_VLAN;
      tag_q      <= TAG_RESET;
      vlan_upd_q <= 1'b0;
      tag_upd_q  <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      shadow_q   <= shadow_d;
      vlan_q     <= vlan_d;
      tag_q      <= tag_d;
      vlan_upd_q <= vlan_upd_d;
      tag_upd_q  <= tag_upd_d;
      init_q     <= 1'b0;
    end
  end
  // Read-back of committed values; the shadow is never visible
  always_comb begin
    rd_data_o = rd_off_i == IF_VLAN_NUM   ? vlan_q[7:0]
              : rd_off_i == IF_VLAN_NUM_1 ? {4'h0, vlan_q[11:8]}
              : rd_off_i == IF_TAG_MODE   ? {4'h0, tag_q}
              : {7'h0, link_up_i};
  end
  assign vlan_o     = vlan_q;
  assign vlan_upd_o = vlan_upd_q;
  assign tag_o      = tag_q;
  assign tag_upd_o  = tag_upd_q;
endmodule

// File: rtl/mgmt_port_config_regs.sv
// mgmt_port_config_regs: byte-wide management register file with die info and per-port config
module mgmt_port_config_regs
  import mgmt_regs_pkg::*;
#(
  parameter int          NUM_PORTS      = 15,
  parameter int          PORT_BITS      = 4,
  parameter int          REGID_BITS     = 10,
  parameter logic [15:0] INTERFACE_BASE = 16'h4000,
  parameter vlan_t       DEFAULT_VLAN   = 12'd1,
  parameter int          RD_TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [15:0]             rd_addr,
  output logic                    rd_valid,
  output logic [7:0]              rd_data,
  output logic                    rd_error,
  input  logic                    wr_en,
  input  logic [15:0]             wr_addr,
  input  logic [7:0]              wr_data,
  output logic                    wr_error,
  input  logic                    idcode_valid,
  input  logic [31:0]             idcode,
  input  logic                    die_serial_valid,
  input  logic [63:0]             die_serial,
  input  logic [NUM_PORTS-1:0]    port_link_up,
  output vlan_t [NUM_PORTS-1:0]   port_vlan,
  output logic [NUM_PORTS-1:0]    port_vlan_updated,
  output logic [NUM_PORTS-1:0]    port_tagged_allowed,
  output logic [NUM_PORTS-1:0]    port_untagged_allowed,
  output logic [NUM_PORTS-1:0]    port_tag_native,
  output logic [NUM_PORTS-1:0]    port_tag_other,
  output logic [NUM_PORTS-1:0]    port_tagmode_updated
);
  localparam int WIN_LSB = REGID_BITS + PORT_BITS;
  localparam logic [15-WIN_LSB:0] WIN_TAG = INTERFACE_BASE[15:WIN_LSB];
  function automatic logic port_hit(input logic [15:0] a);
    return a[15:WIN_LSB] == WIN_TAG && int'(a[REGID_BITS +: PORT_BITS]) < NUM_PORTS
           && a[REGID_BITS-1:2] == '0;
  endfunction
  rd_state_t             state_q, state_d;
  logic [15:0]           addr_q, addr_d, lk_addr;
  logic [7:0]            cnt_q, cnt_d, data_q, data_d, lk_data;
  logic                  err_q, err_d, lk_err, lk_ready, lk_id, lk_sn, lk_pc, lk_port_hit;
  logic [2:0]            sn_idx;
  logic [PORT_BITS-1:0]  lk_port, wr_port;
  logic                  wr_ok, wr_error_q, rd_valid_q, rd_error_q;
  logic [7:0]            rd_data_q;
  logic [7:0]            slice_rd [NUM_PORTS];
  assign wr_port = wr_addr[REGID_BITS +: PORT_BITS];
  assign wr_ok   = port_hit(wr_addr) && ifoff_t'(wr_addr[1:0]) != IF_LINK_STATUS;
  // Read lookup: new request address while idle, latched address while stalled
  always_comb begin
    lk_addr     = state_q == RD_IDLE ? rd_addr : addr_q;
    lk_id       = lk_addr < REG_DIE_SERIAL;
    lk_sn       = lk_addr >= REG_DIE_SERIAL && lk_addr < REG_PORT_COUNT;
    lk_pc       = lk_addr == REG_PORT_COUNT;
    lk_port_hit = port_hit(lk_addr);
    lk_port     = lk_addr[REGID_BITS +: PORT_BITS];
    sn_idx      = 3'(lk_addr[3:0] - 4'd4);
    lk_ready    = lk_id ? idcode_valid : lk_sn ? die_serial_valid : 1'b1;
    lk_err      = !(lk_id || lk_sn || lk_pc || lk_port_hit);
    lk_data     = lk_id ? idcode[{~lk_addr[1:0], 3'b000} +: 8]
                : lk_sn ? die_serial[{~sn_idx, 3'b000} +: 8]
                : lk_pc ? 8'(NUM_PORTS)
                : lk_port_hit ? slice_rd[lk_port] : 8'h00;
  end
  // Read FSM next state; data is captured on entry to RESP so a same-cycle write is not seen
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      RD_IDLE: if (rd_en) begin
        addr_d  = rd_addr;
        cnt_d   = '0;
        data_d  = lk_data;
        err_d   = lk_err;
        state_d = lk_ready ? RD_RESP : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (lk_ready) begin
          state_d = RD_RESP;
          data_d  = lk_data;
          err_d   = lk_err;
        end else if (cnt_d == 8'(RD_TIMEOUT)) begin
          state_d = RD_RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end
  // Read FSM, registered response and write-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_error_q <= 1'b0;
      wr_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rd_valid_q <= state_q == RD_RESP;
      rd_data_q  <= state_q == RD_RESP ? data_q : '0;
      rd_error_q <= state_q == RD_RESP && err_q;
      wr_error_q <= wr_en && !wr_ok;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_error = rd_error_q;
  assign wr_error = wr_error_q;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [3:0] tag;
    mgmt_port_cfg_slice #(.DEFAULT_VLAN(DEFAULT_VLAN)) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en && wr_ok && wr_port == PORT_BITS'(i)),
      .wr_off_i   (ifoff_t'(wr_addr[1:0])),
      .wr_data_i  (wr_data),
      .rd_off_i   (ifoff_t'(lk_addr[1:0])),
      .link_up_i  (port_link_up[i]),
      .vlan_o     (port_vlan[i]),
      .vlan_upd_o (port_vlan_updated[i]),
      .tag_o      (tag),
      .tag_upd_o  (port_tagmode_updated[i]),
      .rd_data_o  (slice_rd[i])
    );
    assign port_tagged_allowed[i]   = tag[0];
    assign port_untagged_allowed[i] = tag[1];
    assign port_tag_native[i]       = tag[2];
    assign port_tag_other[i]        = tag[3];
  end
endmodule

// File: tb/tb_mgmt_port_config_regs.sv
// tb_mgmt_port_config_regs: randomized scoreboard bench against a behavioural register model
module tb_mgmt_port_config_regs;
  localparam int NP = 15;
  localparam int RD_TO = 255;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_en, rd_valid, rd_error, wr_en, wr_error, idcode_valid, die_serial_valid;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0] rd_data, wr_data;
  logic [31:0] idcode;
  logic [63:0] die_serial;
  logic [NP-1:0] port_link_up, port_vlan_updated, port_tagmode_updated;
  logic [NP-1:0] port_tagged_allowed, port_untagged_allowed, port_tag_native, port_tag_other;
  logic [NP-1:0][11:0] port_vlan;
  always #5 clk = ~clk;
  mgmt_port_config_regs dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_error(rd_error),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_error(wr_error),
    .idcode_valid(idcode_valid), .idcode(idcode),
    .die_serial_valid(die_serial_valid), .die_serial(die_serial),
    .port_link_up(port_link_up), .port_vlan(port_vlan), .port_vlan_updated(port_vlan_updated),
    .port_tagged_allowed(port_tagged_allowed), .port_untagged_allowed(port_untagged_allowed),
    .port_tag_native(port_tag_native), .port_tag_other(port_tag_other),
    .port_tagmode_updated(port_tagmode_updated)
  );
  typedef struct {
    logic [7:0] data;
    logic       err;
    int         due;
  } rsp_t;
  rsp_t rq[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [11:0] m_vlan [NP];
  logic [7:0]  m_sh [NP];
  logic [3:0]  m_tag [NP];
  logic        m_init, e_werr, stall;
  logic [NP-1:0] e_vupd, e_tupd;
  logic [15:0] stall_addr;
  int stall_start;
  // Expected {error, data} of a read from the register map description
  function automatic logic [8:0] ref_read(input logic [15:0] a);
    int p, off;
    p = (int'(a) - 'h4000) / 1024;
    off = (int'(a) - 'h4000) % 1024;
    if (a < 16'd4) return {1'b0, 8'(idcode >> (8 * (3 - int'(a))))};
    if (a < 16'd12) return {1'b0, 8'(die_serial >> (8 * (11 - int'(a))))};
    if (a == 16'd12) return {1'b0, 8'(NP)};
    if (a < 16'h4000 || p >= NP || off > 3) return 9'h100;
    case (off)
      0: return {1'b0, m_vlan[p][7:0]};
      1: return {1'b0, 4'h0, m_vlan[p][11:8]};
      2: return {1'b0, 4'h0, m_tag[p]};
      default: return {1'b0, 7'h0, port_link_up[p]};
    endcase
  endfunction
  // Reference model: state updates on each edge, read expectations pushed to the scoreboard
  always @(posedge clk or negedge rst_n) begin
    logic [8:0] r;
    int p, off;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        m_vlan[i] = 12'd1;
        m_sh[i] = 8'd1;
        m_tag[i] = 4'b0010;
      end
      m_init = 1'b1;
      e_vupd = '0;
      e_tupd = '0;
      e_werr = 1'b0;
      stall = 1'b0;
      rq.delete();
    end else begin
      cyc++;
      e_vupd = m_init ? '1 : '0;
      e_tupd = m_init ? '1 : '0;
      m_init = 1'b0;
      e_werr = 1'b0;
      if (stall) begin
        if (stall_addr < 16'd4 ? idcode_valid : die_serial_valid) begin
          r = ref_read(stall_addr);
          rq.push_back('{r[7:0], r[8], cyc + 1});
          stall = 1'b0;
        end else if (cyc - stall_start == RD_TO) begin
          rq.push_back('{8'h00, 1'b1, cyc + 1});
          stall = 1'b0;
        end
      end
      if (rd_en) begin
        if ((rd_addr < 16'd4 && !idcode_valid) || (rd_addr >= 16'd4 && rd_addr < 16'd12 && !die_serial_valid)) begin
          stall = 1'b1;
          stall_addr = rd_addr;
          stall_start = cyc;
        end else begin
          r = ref_read(rd_addr);
          rq.push_back('{r[7:0], r[8], cyc + 1});
        end
      end
      if (wr_en) begin
        p = (int'(wr_addr) - 'h4000) / 1024;
        off = (int'(wr_addr) - 'h4000) % 1024;
        if (wr_addr < 16'h4000 || p >= NP || off > 2) e_werr = 1'b1;
        else if (off == 0) m_sh[p] = wr_data;
        else if (off == 1) begin
          m_vlan[p] = {wr_data[3:0], m_sh[p]};
          e_vupd[p] = 1'b1;
        end else begin
          m_tag[p] = wr_data[3:0];
          e_tupd[p] = 1'b1;
        end
      end
    end
  end
  // Monitor: compares DUT outputs against model state and pops read responses
  always @(negedge clk) begin
    rsp_t e;
    checks++;
    if (wr_error !== e_werr) begin
      errors++;
      $display("FAIL wr_error cyc %0d got %b exp %b", cyc, wr_error, e_werr);
    end
    checks++;
    if (port_vlan_updated !== e_vupd || port_tagmode_updated !== e_tupd) begin
      errors++;
      $display("FAIL strobes cyc %0d got vlan %h tag %h exp vlan %h tag %h", cyc,
               port_vlan_updated, port_tagmode_updated, e_vupd, e_tupd);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (port_vlan[i] !== m_vlan[i] ||
          {port_tag_other[i], port_tag_native[i], port_untagged_allowed[i], port_tagged_allowed[i]} !== m_tag[i]) begin
        errors++;
        $display("FAIL port_cfg %0d cyc %0d got vlan %h tag %b exp vlan %h tag %b", i, cyc, port_vlan[i],
                 {port_tag_other[i], port_tag_native[i], port_untagged_allowed[i], port_tagged_allowed[i]},
                 m_vlan[i], m_tag[i]);
      end
    end
    if (rd_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected cyc %0d got data %h err %b exp no response", cyc, rd_data, rd_error);
      end else begin
        e = rq.pop_front();
        if (rd_data !== e.data || rd_error !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL read cyc %0d got data %h err %b exp data %h err %b at cyc %0d", cyc, rd_data,
                   rd_error, e.data, e.err, e.due);
        end
      end
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rd_missing cyc %0d got no rd_valid exp data %h err %b", cyc, rq[0].data, rq[0].err);
      void'(rq.pop_front());
    end
  end
  task automatic op(input logic r, input logic [15:0] ra, input logic w, input logic [15:0] wa,
                    input logic [7:0] wd);
    @(negedge clk);
    rd_en = r;
    rd_addr = ra;
    wr_en = w;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask
  task automatic drain();
    int g = 0;
    while ((rq.size() != 0 || stall) && g < 600) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 600) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", rq.size());
      rq.delete();
      stall = 1'b0;
    end
  endtask
  function automatic logic [15:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return 16'($urandom_range(0, 15));
    if (k == 1) return 16'($urandom);
    return 16'h4000 + 16'($urandom_range(0, 15)) * 16'h0400 + 16'($urandom_range(0, 4));
  endfunction
  initial begin
    logic [15:0] a;
    logic [7:0] d;
    int k;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    idcode = $urandom;
    die_serial = {$urandom, $urandom};
    idcode_valid = 1'b1;
    die_serial_valid = 1'b1;
    port_link_up = NP'($urandom);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    op(1, 16'h400C, 0, 0, 0); drain();
    op(1, 16'h000C, 0, 0, 0); drain();
    op(0, 0, 1, 16'h4400, 8'h34);
    op(0, 0, 1, 16'h4401, 8'hA2);
    op(1, 16'h4400, 0, 0, 0); drain();
    op(1, 16'h4401, 0, 0, 0); drain();
    op(0, 0, 1, 16'h7C02, 8'h05);
    op(0, 0, 1, 16'h0000, 8'hFF);
    op(1, 16'h4004, 0, 0, 0); drain();
    op(0, 0, 1, 16'h4801, 8'h07);
    op(0, 0, 1, 16'h4801, 8'h0C);
    op(0, 0, 1, 16'h4C03, 8'h01);
    op(1, 16'h4802, 1, 16'h4802, 8'hFD); drain();
    op(1, 16'h4802, 0, 0, 0); drain();
    repeat (400) begin
      k = $urandom_range(0, 5);
      a = rand_addr();
      d = 8'($urandom);
      if (k <= 2) op(0, 0, 1, a, d);
      else if (k == 3) begin op(1, a, 0, 0, 0); drain(); end
      else if (k == 4) begin op(1, a, 1, a, d); drain(); end
      else begin @(negedge clk); port_link_up = NP'($urandom); end
    end
    @(negedge clk) idcode_valid = 1'b0;
    op(1, 16'h0000, 0, 0, 0);
    repeat (10) @(negedge clk);
    idcode = 32'h0362D093;
    idcode_valid = 1'b1;
    drain();
    @(negedge clk) die_serial_valid = 1'b0;
    op(1, 16'h0004, 0, 0, 0); drain();
    op(1, 16'h0007, 0, 0, 0);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    die_serial_valid = 1'b1;
    op(1, 16'h0007, 0, 0, 0); drain();
    op(0, 0, 1, 16'h5002, 8'hFF);
    op(1, 16'h5002, 0, 0, 0); drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
